// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: control sequencer for one fully-connected layer.
// It loads the x vector into x memory, walks the weight ROM one output group
// at a time, and presents the P lane results over a valid/ready stream.
//
//   state | meaning
//   LOAD  | accept N x elements, write them into x memory
//   MAC   | issue one x/w read per cycle for the current output group
//   DRAIN | wait RD_LAT cycles so the last reads reach the accumulators
//   OUT   | present lane j of the group, advance on each handshake
`timescale 1ns/1ps
module fc_layer_sequencer #(
  parameter int M      = 6,
  parameter int N      = 6,
  parameter int T      = 8,
  parameter int P      = 1,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic                      output_ready,
  output logic                      output_valid,
  output logic [$clog2(N)-1:0]      addr_x,
  output logic                      wr_en_x,
  output logic [$clog2(M*N/P)-1:0]  addr_w,
  output logic                      clear_acc,
  output logic                      en_acc,
  output logic [P-1:0]              f_sel
);

  localparam int XW = $clog2(N);
  localparam int WW = $clog2(M*N/P);
  localparam int G  = M / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;
  // T only names the datapath word width; the drain length is the read latency.
  localparam int DRAIN_CYC = (T > 0) ? RD_LAT : RD_LAT;

  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic [GW-1:0] G_LAST     = GW'(G - 1);
  localparam logic [JW-1:0] J_LAST     = JW'(P - 1);
  localparam logic [1:0]    DRAIN_INIT = 2'(DRAIN_CYC - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]        state;
  logic [XW-1:0]     i_cnt;
  logic [XW-1:0]     k_cnt;
  logic [GW-1:0]     g_cnt;
  logic [JW-1:0]     j_cnt;
  logic [1:0]        drain_cnt;
  logic [WW-1:0]     w_cnt;
  logic [RD_LAT-1:0] en_pipe;
  logic              issue;
  logic              in_hs;
  logic              out_hs;

  assign issue  = (state == S_MAC);
  assign in_hs  = (state == S_LOAD) && input_valid && input_ready;
  assign out_hs = (state == S_OUT) && output_ready;

  // Outputs are decoded from registered state, so they are all zero while reset is held.
  assign addr_x       = (state == S_LOAD) ? i_cnt : k_cnt;
  assign wr_en_x      = in_hs;
  assign addr_w       = w_cnt;
  assign clear_acc    = issue && (k_cnt == '0);
  assign en_acc       = en_pipe[RD_LAT-1];
  assign output_valid = (state == S_OUT);
  assign f_sel        = (state == S_OUT) ? (P'(1) << j_cnt) : '0;

  // Main sequencing FSM: counters advance with the state they belong to.
  // w_cnt is the running weight address; it holds on the last issue of a group
  // and steps on the group hand-over, so addr_w holds through DRAIN and OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_LOAD;
      i_cnt       <= '0;
      k_cnt       <= '0;
      g_cnt       <= '0;
      j_cnt       <= '0;
      drain_cnt   <= '0;
      w_cnt       <= '0;
      input_ready <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          input_ready <= 1'b1;
          if (in_hs) begin
            if (i_cnt == X_LAST) begin
              state       <= S_MAC;
              i_cnt       <= '0;
              g_cnt       <= '0;
              k_cnt       <= '0;
              w_cnt       <= '0;
              input_ready <= 1'b0;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (k_cnt == X_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else begin
            k_cnt <= k_cnt + 1'b1;
            w_cnt <= w_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_OUT;
            j_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (out_hs) begin
            if (j_cnt == J_LAST) begin
              if (g_cnt == G_LAST) begin
                state       <= S_LOAD;
                i_cnt       <= '0;
                g_cnt       <= '0;
                w_cnt       <= '0;
                input_ready <= 1'b1;
              end else begin
                state <= S_MAC;
                g_cnt <= g_cnt + 1'b1;
                k_cnt <= '0;
                w_cnt <= w_cnt + 1'b1;
              end
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Delay each issue by the memory read latency so en_acc lines up with read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= issue;
      for (int n = 1; n < RD_LAT; n++) begin
        en_pipe[n] <= en_pipe[n-1];
      end
    end
  end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Control sequencer for one fully-connected layer datapath: an x-vector RAM, a per-lane weight ROM, P MAC accumulators with ReLU, and a lane output mux.
- Accepts an N-element input vector over a valid/ready stream and writes it into x memory.
- Steps weight/x addresses through every output group, drives accumulator clear/enable with read-latency alignment, then emits P results per group over a valid/ready stream.
- Sits between the layer's top-level ports and its datapath; weights come from ROM, so there is no weight write path.

Parameters:
M, 6, number of output neurons (rows); M % P == 0 required
N, 6, number of inputs (columns); N >= 2 required
T, 8, data width (passed through for consistency, not used internally)
P, 1, parallel MAC lanes; each group produces P outputs
RD_LAT, 1, read latency in cycles of x memory and weight ROM (1..3)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
input_valid  input  1  upstream data valid
input_ready  output  1  sequencer accepting input elements
output_ready  input  1  downstream ready
output_valid  output  1  datapath output (lane f_sel) valid
addr_x  output  $clog2(N)  x memory address (write in LOAD, read in MAC)
wr_en_x  output  1  x memory write enable
addr_w  output  $clog2(M*N/P)  weight ROM address
clear_acc  output  1  zero all accumulators
en_acc  output  1  accumulate enable, aligned to read data
f_sel  output  P  one-hot output lane select

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low. While reset is low, every output is 0, state = LOAD, and all counters (i, g, k, j, en pipe) are 0.
- input_ready is registered: 0 during reset, 1 from the first cycle after release while in LOAD.
- State LOAD:
  - addr_x = i; wr_en_x = input_valid & input_ready.
  - On handshake, i++.
  - Handshake at i == N-1: go to MAC (g = 0, k = 0); input_ready = 0 next cycle.
  - input_valid is ignored in every other state.
- State MAC:
  - Each cycle issues addr_x = k, addr_w = g*N + k, then k++.
  - clear_acc = 1 in the k == 0 issue cycle only.
  - en_acc = issue-valid delayed by RD_LAT cycles through a shift register.
  - After issuing k == N-1: go to DRAIN.
- State DRAIN: lasts RD_LAT cycles so the en_acc pipe empties; addresses hold last value; then go to OUT with j = 0.
- State OUT:
  - output_valid = 1, f_sel = 1 << j; clear_acc = en_acc = 0.
  - On output_valid & output_ready: j++.
  - After lane P-1 handshakes: if g == M/P-1, go to LOAD (i = 0); else g++, k = 0, go to MAC.
  - output_ready low: remain in OUT with all outputs stable.
- Latency (P=1, RD_LAT=1, N=6):
  - Last input handshake at cycle c.
  - MAC issues at c+1..c+6; en_acc at c+2..c+7.
  - output_valid first high at c+8.
  - Each subsequent group: N + RD_LAT + 1 cycles from its output handshake to its own output_valid.
- Counts: exactly N en_acc pulses and one clear_acc per group. addr_w covers 0..M*N/P-1 once per frame, in order. No overlap between the next frame's LOAD and the previous frame's OUT.
- Reset mid-operation aborts immediately with no pending pulses after release. x memory contents are not cleared; the next LOAD overwrites them.

Test Plan:
- Reset: hold reset low 3 cycles with input_valid=1 -> all outputs 0, wr_en_x=0; input_ready=1 on the first cycle after release.
- Full frame, defaults: stream 1..6 back-to-back, output_ready=1 -> addr_x 0..5 with wr_en_x; addr_w 0..35; six clear_acc and 36 en_acc pulses; first output_valid 8 cycles after the last input handshake; 6 output handshakes; input_ready returns to 1.
- Input gaps: input_valid pattern 1,0,0,1,1,0,1,1,1 -> wr_en_x only on handshake cycles; addr_x increments only then; MAC starts after the sixth accept.
- Backpressure: hold output_ready=0 for 5 cycles in OUT of group 2 -> output_valid, f_sel, addr_w stable; no clear_acc/en_acc; resumes with addr_w = 18 issuing the next group.
- Async reset mid-MAC at k=3 of group 1 -> outputs 0 in the same cycle; after release, LOAD with addr_x = 0 and no stray en_acc.
- P=2, RD_LAT=2: 3 groups; f_sel 01 then 10 per group; addr_w 0..17; en_acc lags issue by 2 cycles; DRAIN lasts 2 cycles.
